// File: rtl/cis_line_sequencer.sv
// CIS line sequencer: start pulse, dummy skip, dual-ADC pixel pair packing into a FWFT FIFO, end-of-line interrupt.
// Packed word is visible one cycle after its odd-pixel sample; a push into a full FIFO without rd_en is dropped and sets ovf.

module cis_fwft_fifo #(
  parameter int DW = 32,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count
);
  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;
  logic [AW:0]   count_nxt;

  assign full      = (count == (AW+1)'(DEPTH));
  assign do_pop    = pop & ~empty;
  // A pop frees its slot in the same cycle, so a full FIFO still takes the push.
  assign do_push   = push & (~full | do_pop);
  assign count_nxt = count + (AW+1)'(do_push) - (AW+1)'(do_pop);
  assign head      = mem[rptr];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      empty <= 1'b1;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      count <= count_nxt;
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_data;
  end
endmodule

module cis_line_sequencer #(
  parameter int SP_WIDTH   = 4,
  parameter int DUMMY_PIX  = 16,
  parameter int ACTIVE_PIX = 1024,
  parameter int FIFO_AW    = 4
) (
  input  logic               adc_clk,
  input  logic               reset_n,
  input  logic               start_cis,
  input  logic [15:0]        sp_para,
  input  logic [7:0]         ad1_data,
  input  logic [7:0]         ad2_data,
  input  logic               rd_en,
  input  logic               int_ack,
  output logic               cis_sp,
  output logic               cis_wren,
  output logic [31:0]        rd_data,
  output logic               fifo_empty,
  output logic [FIFO_AW:0]   fifo_count,
  output logic               dsp_int,
  output logic               ovf
);
  localparam int PIX_MAX = (ACTIVE_PIX > DUMMY_PIX) ? ACTIVE_PIX : DUMMY_PIX;
  localparam int PW      = $clog2(PIX_MAX) + 1;

  typedef enum logic [2:0] {IDLE, SP, DUMMY, ACTIVE, WAIT} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [15:0]   pcnt;
  logic [15:0]   sp_lat;
  logic [PW-1:0] pix;
  logic          ph;
  logic [15:0]   half;
  logic          sample;
  logic          line_done;
  logic          period_done;
  logic          push;
  logic          fifo_full;
  logic [31:0]   push_word;
  logic          cis_sp_nxt;
  logic          cis_wren_nxt;

  assign sample      = ph & ((state == DUMMY) | (state == ACTIVE));
  assign line_done   = (state == ACTIVE) & ph & (pix == PW'(ACTIVE_PIX - 1));
  // pcnt + 1 >= sp_lat, widened so sp_lat = 0 cannot underflow
  assign period_done = (({1'b0, pcnt} + 17'd1) >= {1'b0, sp_lat});
  assign push        = (state == ACTIVE) & ph & pix[0];
  assign push_word   = {ad2_data, ad1_data, half};

  // State register
  always_ff @(posedge adc_clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_cis) state_nxt = SP;
      SP:      if (pcnt == 16'(SP_WIDTH - 1)) state_nxt = DUMMY;
      DUMMY:   if (ph && (pix == PW'(DUMMY_PIX - 1))) state_nxt = ACTIVE;
      ACTIVE:  if (line_done) state_nxt = WAIT;
      WAIT:    if (period_done) state_nxt = start_cis ? SP : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode, registered below so outputs align with the state they describe
  always_comb begin
    cis_sp_nxt   = (state_nxt == SP);
    cis_wren_nxt = (state_nxt == ACTIVE);
  end

  always_ff @(posedge adc_clk) begin
    if (!reset_n) begin
      pcnt     <= '0;
      sp_lat   <= '0;
      pix      <= '0;
      ph       <= 1'b0;
      half     <= '0;
      cis_sp   <= 1'b0;
      cis_wren <= 1'b0;
      dsp_int  <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      cis_sp   <= cis_sp_nxt;
      cis_wren <= cis_wren_nxt;

      if ((state_nxt == SP) && (state != SP)) begin
        pcnt   <= '0;
        sp_lat <= sp_para;
      end else if (state != IDLE) begin
        pcnt <= pcnt + 16'd1;
      end

      // Pixel phase and sample index restart on every state change.
      if (state_nxt != state) begin
        ph  <= 1'b0;
        pix <= '0;
      end else if ((state == DUMMY) || (state == ACTIVE)) begin
        ph <= ~ph;
        if (ph) pix <= pix + PW'(1);
      end

      if (sample && (state == ACTIVE) && !pix[0]) half <= {ad2_data, ad1_data};

      if (line_done)                    dsp_int <= 1'b1;
      else if (int_ack)                 dsp_int <= 1'b0;

      if (push && fifo_full && !rd_en)  ovf <= 1'b1;
      else if (int_ack)                 ovf <= 1'b0;
    end
  end

  cis_fwft_fifo #(
    .DW (32),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk       (adc_clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_word),
    .pop       (rd_en),
    .head      (rd_data),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );
endmodule

// File: tb/tb_cis_line_sequencer.sv
// Directed bench for cis_line_sequencer with SP_WIDTH=4, DUMMY_PIX=2, ACTIVE_PIX=8, FIFO_AW=2 (line length L=24).
module tb_cis_line_sequencer;
  localparam int SPW  = 4;
  localparam int DPX  = 2;
  localparam int APX  = 8;
  localparam int AW   = 2;
  localparam int AST  = SPW + 2 * DPX;
  localparam int AEND = AST + 2 * APX;

  logic          adc_clk   = 1'b0;
  logic          reset_n   = 1'b0;
  logic          start_cis = 1'b0;
  logic [15:0]   sp_para   = 16'd40;
  logic [7:0]    ad1_data  = 8'h00;
  logic [7:0]    ad2_data  = 8'h00;
  logic          rd_en     = 1'b0;
  logic          int_ack   = 1'b0;
  logic          cis_sp;
  logic          cis_wren;
  logic [31:0]   rd_data;
  logic          fifo_empty;
  logic [AW:0]   fifo_count;
  logic          dsp_int;
  logic          ovf;

  int n_chk = 0;
  int n_pass = 0;
  int mp = 0;
  int per = 40;
  int ln = 0;
  int cyc = 0;

  cis_line_sequencer #(
    .SP_WIDTH   (SPW),
    .DUMMY_PIX  (DPX),
    .ACTIVE_PIX (APX),
    .FIFO_AW    (AW)
  ) dut (
    .adc_clk    (adc_clk),
    .reset_n    (reset_n),
    .start_cis  (start_cis),
    .sp_para    (sp_para),
    .ad1_data   (ad1_data),
    .ad2_data   (ad2_data),
    .rd_en      (rd_en),
    .int_ack    (int_ack),
    .cis_sp     (cis_sp),
    .cis_wren   (cis_wren),
    .rd_data    (rd_data),
    .fifo_empty (fifo_empty),
    .fifo_count (fifo_count),
    .dsp_int    (dsp_int),
    .ovf        (ovf)
  );

  always #25 adc_clk = ~adc_clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [7:0] pix1(int l, int k);
    return 8'(k + 16 * l);
  endfunction

  function automatic logic [31:0] word(int l, int j);
    logic [7:0] a0;
    logic [7:0] a1;
    a0 = pix1(l, 2 * j);
    a1 = pix1(l, 2 * j + 1);
    return {8'h80 + a1, a1, 8'h80 + a0, a0};
  endfunction

  // Word j becomes visible on the cycle after its odd-pixel sample at pcnt AST+4j+3.
  function automatic int exp_cnt(int p);
    int c;
    c = 0;
    for (int j = 0; j < APX / 2; j++) if (p >= AST + 4 * j + 4) c++;
    return c;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Advance one cycle; mp tracks the expected pcnt, and ADC data for pixel k is k + 16*line.
  task automatic tick();
    @(posedge adc_clk);
    #1;
    cyc++;
    mp = (mp + 1) % per;
    if (mp == 0) ln++;
    if (mp >= AST && mp < AEND) begin
      ad1_data = pix1(ln, (mp - AST) / 2);
      ad2_data = 8'h80 + ad1_data;
    end else begin
      ad1_data = 8'hEE;
      ad2_data = 8'hEE;
    end
  endtask

  task automatic launch();
    start_cis = 1'b1;
    mp = per - 1;
    ln = -1;
    tick();
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    start_cis = 1'b0;
    rd_en     = 1'b0;
    int_ack   = 1'b0;
    sp_para   = 16'd40;
    per       = 40;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic pop_check(input string tag, input int l, input int j);
    check(tag, rd_data, word(l, j));
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic wait_rise(output int t);
    logic prev;
    prev = cis_sp;
    t = -1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (cis_sp && !prev) begin
        t = cyc;
        break;
      end
      prev = cis_sp;
    end
    check("sp_rise_seen", 32'(t >= 0), 32'd1);
  endtask

  task automatic count_rises(input int n, output int rises);
    logic prev;
    prev = cis_sp;
    rises = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (cis_sp && !prev) rises++;
      prev = cis_sp;
    end
  endtask

  initial begin
    int t0, t1, t2, t3, t4, r;

    // Reset state
    do_reset();
    check("rst_sp",    32'(cis_sp),     32'd0);
    check("rst_wren",  32'(cis_wren),   32'd0);
    check("rst_int",   32'(dsp_int),    32'd0);
    check("rst_ovf",   32'(ovf),        32'd0);
    check("rst_empty", 32'(fifo_empty), 32'd1);
    check("rst_count", 32'(fifo_count), 32'd0);

    // Single line, start_cis held for one cycle only
    do_reset();
    launch();
    start_cis = 1'b0;
    for (int i = 0; i < 40; i++) begin
      check("line_sp",    32'(cis_sp),     32'(i < SPW));
      check("line_wren",  32'(cis_wren),   32'(i >= AST && i < AEND));
      check("line_int",   32'(dsp_int),    32'(i >= AEND));
      check("line_count", 32'(fifo_count), 32'(exp_cnt(i)));
      check("line_empty", 32'(fifo_empty), 32'(exp_cnt(i) == 0));
      tick();
    end
    count_rises(45, r);
    check("line_no_restart", 32'(r), 32'd0);
    for (int j = 0; j < 4; j++) pop_check("line_word", 0, j);
    check("line_drained", 32'(fifo_empty), 32'd1);
    check("line_int_held", 32'(dsp_int), 32'd1);
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    check("line_int_ack", 32'(dsp_int), 32'd0);

    // Continuous run: period 40, then sp_para=10 gives L+1 = 25
    do_reset();
    start_cis = 1'b1;
    wait_rise(t0);
    wait_rise(t1);
    check("period_40a", 32'(t1 - t0), 32'd40);
    sp_para = 16'd10;
    wait_rise(t2);
    check("period_40b", 32'(t2 - t1), 32'd40);
    wait_rise(t3);
    check("period_25a", 32'(t3 - t2), 32'd25);
    wait_rise(t4);
    check("period_25b", 32'(t4 - t3), 32'd25);
    start_cis = 1'b0;

    // Overflow: two lines, no reads
    do_reset();
    launch();
    for (int i = 0; i < 39; i++) tick();
    check("ovf_l1_count", 32'(fifo_count), 32'd4);
    check("ovf_l1_flag",  32'(ovf),        32'd0);
    tick();
    start_cis = 1'b0;
    check("ovf_l2_sp", 32'(cis_sp), 32'd1);
    for (int i = 0; i < 39; i++) tick();
    check("ovf_count", 32'(fifo_count), 32'd4);
    check("ovf_flag",  32'(ovf),        32'd1);
    check("ovf_int",   32'(dsp_int),    32'd1);
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    check("ovf_ack_flag", 32'(ovf),     32'd0);
    check("ovf_ack_int",  32'(dsp_int), 32'd0);
    for (int j = 0; j < 4; j++) pop_check("ovf_word", 0, j);
    check("ovf_drained", 32'(fifo_empty), 32'd1);

    // Push and pop together while full
    do_reset();
    launch();
    for (int i = 0; i < 40; i++) tick();
    start_cis = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (mp >= AST + 3 && mp <= AEND - 1 && (mp % 4) == 3) begin
        check("pp_head", rd_data, word(0, (mp - AST - 3) / 4));
        rd_en = 1'b1;
      end
      tick();
      rd_en = 1'b0;
      if (mp >= AST + 4 && mp <= AEND && (mp % 4) == 0) begin
        check("pp_count", 32'(fifo_count), 32'd4);
        check("pp_ovf",   32'(ovf),        32'd0);
      end
    end
    for (int j = 0; j < 4; j++) pop_check("pp_word", 1, j);
    check("pp_drained", 32'(fifo_empty), 32'd1);

    // Stop mid-line at pcnt 10
    do_reset();
    launch();
    for (int i = 0; i < 10; i++) tick();
    start_cis = 1'b0;
    for (int i = 0; i < 29; i++) tick();
    check("stop_count", 32'(fifo_count), 32'd4);
    check("stop_int",   32'(dsp_int),    32'd1);
    count_rises(50, r);
    check("stop_no_restart", 32'(r), 32'd0);
    for (int j = 0; j < 4; j++) pop_check("stop_word", 0, j);

    // Reset for one cycle at pcnt 15, start_cis still high
    do_reset();
    launch();
    for (int i = 0; i < 14; i++) tick();
    check("mrst_wren_pre",  32'(cis_wren),   32'd1);
    check("mrst_count_pre", 32'(fifo_count), 32'd1);
    tick();
    reset_n = 1'b0;
    tick();
    check("mrst_sp",    32'(cis_sp),     32'd0);
    check("mrst_wren",  32'(cis_wren),   32'd0);
    check("mrst_empty", 32'(fifo_empty), 32'd1);
    check("mrst_count", 32'(fifo_count), 32'd0);
    check("mrst_int",   32'(dsp_int),    32'd0);
    check("mrst_ovf",   32'(ovf),        32'd0);
    reset_n = 1'b1;
    tick();
    check("mrst_restart_sp", 32'(cis_sp), 32'd1);
    tick();
    check("mrst_restart_empty", 32'(fifo_empty), 32'd1);
    start_cis = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
